// File: rtl/square_wave_bank.sv
// square_wave_bank: multi-channel glitch-free square-wave tone source with a registered population count of active waves; SQUARE_WAVE_BANK_DUTY_EN enables programmable duty (otherwise fixed 50%)
module square_wave_bank #(
  parameter int CHANNELS   = 4,
  parameter int CNT_W      = 32,
  parameter int CLK_PERIOD = 20
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [CHANNELS-1:0]           en,
  input  logic [CHANNELS*CNT_W-1:0]     period,
  input  logic [CHANNELS*8-1:0]         duty,
  output logic [CHANNELS-1:0]           wave,
  output logic [CHANNELS-1:0]           tick,
  output logic [$clog2(CHANNELS+1)-1:0] mix
);
  localparam int MW = $clog2(CHANNELS+1);
  localparam logic [CNT_W:0] STEP = (CNT_W+1)'(CLK_PERIOD);
  typedef enum logic {IDLE, RUN} state_t;
`ifndef SQUARE_WAVE_BANK_DUTY_EN
  logic unused_duty;
  assign unused_duty = ^duty;
`endif
  genvar c;
  for (c = 0; c < CHANNELS; c++) begin : ch
    state_t st;
    logic [CNT_W-1:0] cnt, p_act, hi, p_in, hi_new;
    logic [CNT_W:0] nxt;
    logic valid, wrap, w, t;
    assign p_in  = period[c*CNT_W +: CNT_W];
    assign valid = p_in >= CNT_W'(CLK_PERIOD);
    assign nxt   = {1'b0, cnt} + STEP;
    assign wrap  = nxt >= {1'b0, p_act};
`ifdef SQUARE_WAVE_BANK_DUTY_EN
    logic [CNT_W+7:0] prod;
    assign prod   = {8'b0, p_in} * {{CNT_W{1'b0}}, duty[c*8 +: 8]};
    assign hi_new = prod[CNT_W+7:8];
`else
    assign hi_new = p_in >> 1;
`endif
    assign wave[c] = w;
    assign tick[c] = t;
    // channel FSM: start, count, wrap with shadow re-latch, and registered wave/tick from next-state values
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        st    <= IDLE;
        cnt   <= '0;
        p_act <= '0;
        hi    <= '0;
        w     <= 1'b0;
        t     <= 1'b0;
      end else if (!en[c]) begin
        st  <= IDLE;
        cnt <= '0;
        w   <= 1'b0;
        t   <= 1'b0;
      end else if (st == IDLE) begin
        t <= 1'b0;
        if (valid) begin
          st    <= RUN;
          cnt   <= '0;
          p_act <= p_in;
          hi    <= hi_new;
          w     <= hi_new != '0;
        end else begin
          w <= 1'b0;
        end
      end else if (wrap) begin
        cnt   <= '0;
        p_act <= p_in;
        hi    <= hi_new;
        st    <= valid ? RUN : IDLE;
        t     <= valid;
        w     <= valid && hi_new != '0;
      end else begin
        cnt <= nxt[CNT_W-1:0];
        t   <= 1'b0;
        w   <= nxt[CNT_W-1:0] < hi;
      end
  end
  logic [MW-1:0] pc;
  // population count of the current waves
  always_comb begin
    pc = '0;
    for (int k = 0; k < CHANNELS; k++) pc = pc + MW'(wave[k]);
  end
  // mix lags wave by one cycle
  always_ff @(posedge clk or posedge rst)
    if (rst) mix <= '0;
    else mix <= pc;
endmodule

// File: tb/tb_square_wave_bank.sv
// tb_square_wave_bank: randomized check of square_wave_bank against a cycle-count reference model
module tb_square_wave_bank;
  logic clk = 1'b0;
  logic rst;
  logic [3:0] en;
  logic [127:0] period;
  logic [31:0] duty;
  logic [3:0] wave, tick;
  logic [2:0] mix;
  int n_tests = 0, n_fail = 0;
  bit run[4], first[4];
  int k[4], n[4], h[4];
  int exp_mix;
  logic [4:0] pat = 5'b00111;

  square_wave_bank #(.CHANNELS(4), .CNT_W(32), .CLK_PERIOD(20)) dut (
    .clk(clk), .rst(rst), .en(en), .period(period), .duty(duty),
    .wave(wave), .tick(tick), .mix(mix)
  );

  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_wave(int c);
    return run[c] && k[c] < h[c];
  endfunction

  function automatic bit m_tick(int c);
    return run[c] && k[c] == 0 && !first[c];
  endfunction

  // latch cycle counts for a new period: N cycles total, ceil(hi/20) high, capped at N
  task automatic latch(input int c);
    int p, hv;
    p = int'(period[c*32 +: 32]);
`ifdef SQUARE_WAVE_BANK_DUTY_EN
    hv = (p * int'(duty[c*8 +: 8])) >> 8;
`else
    hv = p >> 1;
`endif
    n[c] = (p + 19) / 20;
    h[c] = (hv + 19) / 20;
    if (h[c] > n[c]) h[c] = n[c];
  endtask

  task automatic model_edge();
    int p;
    exp_mix = 0;
    for (int c = 0; c < 4; c++) exp_mix += int'(m_wave(c));
    for (int c = 0; c < 4; c++) begin
      p = int'(period[c*32 +: 32]);
      if (!en[c]) run[c] = 0;
      else if (!run[c]) begin
        if (p >= 20) begin
          run[c] = 1; k[c] = 0; first[c] = 1; latch(c);
        end
      end else if (k[c] + 1 == n[c]) begin
        if (p >= 20) begin
          k[c] = 0; first[c] = 0; latch(c);
        end else run[c] = 0;
      end else k[c]++;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    for (int c = 0; c < 4; c++) begin
      check($sformatf("wave%0d", c), 32'(wave[c]), 32'(m_wave(c)));
      check($sformatf("tick%0d", c), 32'(tick[c]), 32'(m_tick(c)));
    end
    check("mix", 32'(mix), 32'(exp_mix));
  endtask

  task automatic async_reset();
    #2;
    rst = 1'b1;
    #1;
    check("rst_wave", 32'(wave), 0);
    check("rst_tick", 32'(tick), 0);
    check("rst_mix", 32'(mix), 0);
    for (int c = 0; c < 4; c++) run[c] = 0;
    exp_mix = 0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_ch(input int c, input int p, input int d);
    period[c*32 +: 32] = 32'(p);
    duty[c*8 +: 8] = 8'(d);
  endtask

  initial begin
    rst = 1'b1; en = '0; period = '0; duty = '0;
    for (int c = 0; c < 4; c++) begin run[c] = 0; first[c] = 0; k[c] = 0; n[c] = 1; h[c] = 0; end
    exp_mix = 0;
    #12;
    check("reset_wave", 32'(wave), 0);
    check("reset_tick", 32'(tick), 0);
    check("reset_mix", 32'(mix), 0);
    @(negedge clk);
    rst = 1'b0;
    set_ch(0, 100, 128); set_ch(1, 90, 64); set_ch(2, 19, 200);
    en = 4'b0111;
    for (int i = 0; i < 15; i++) begin
      step();
      check("pat_wave0", 32'(wave[0]), 32'(pat[i % 5]));
      check("pat_tick0", 32'(tick[0]), 32'(i >= 5 && i % 5 == 0));
    end
    step(); step();
    set_ch(0, 200, 128);
    for (int i = 0; i < 25; i++) step();
    set_ch(0, 0, 128); set_ch(1, 0, 64);
    for (int i = 0; i < 15; i++) step();
    set_ch(0, 100, 128);
    for (int i = 0; i < 3; i++) step();
    en[0] = 1'b0;
    step();
    check("dis_wave0", 32'(wave[0]), 0);
    en[0] = 1'b1;
    for (int i = 0; i < 7; i++) step();
    async_reset();
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 4; c++) begin
        if ($urandom_range(0, 99) < 2) en[c] = ~en[c];
        if ($urandom_range(0, 99) < 5)
          period[c*32 +: 32] = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 19) : $urandom_range(20, 300);
        if ($urandom_range(0, 99) < 5) duty[c*8 +: 8] = 8'($urandom_range(0, 255));
      end
      if ($urandom_range(0, 499) == 0) async_reset();
      step();
    end
    for (int c = 0; c < 4; c++) set_ch(c, 100 * (c + 1), 128);
    en = 4'b1111;
    for (int i = 0; i < 1200; i++) begin
      step();
      check("mix_range", 32'(mix <= 3'd4), 1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
